fetch_decode_control: RTL

FETCH_DECODE_CONTROL -- requirements
Module: fetch_decode_control

---
 rtl/fetch_decode_control.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fetch_decode_control.sv
// ============================================================================
// Module      : fetch_decode_control
// Description : Three-phase fetch/decode/execute controller producing the
//               34-bit ALUSystem control word. Optional macro
//               FDC_ILLEGAL_TRAP_EN halts on opcodes 1011-1111.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_decode_control (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALUOutFlag,
    output logic [33:0] CtrlWord,
    output logic [7:0]  T,
    output logic        Halt
);

    localparam logic [1:0] S_FETCH_L = 2'd0;
    localparam logic [1:0] S_FETCH_H = 2'd1;
    localparam logic [1:0] S_EXEC    = 2'd2;
    localparam logic [1:0] S_HALT    = 2'd3;

    localparam logic [3:0] c_OP_LDI  = 4'b1000;
    localparam logic [3:0] c_OP_BEQ  = 4'b1001;
    localparam logic [3:0] c_OP_HLT  = 4'b1010;

    logic [1:0] r_state;
    logic [7:0] r_t;
    logic       r_halt;

    logic [1:0] w_next_state;
    logic [7:0] w_t_next;
    logic       w_trap;

    logic [3:0] w_opcode;
    logic [1:0] w_dst;
    logic [3:0] w_dst_sel;

    logic [1:0] w_rf_outasel;
    logic [1:0] w_rf_outbsel;
    logic [1:0] w_rf_funsel;
    logic [3:0] w_rf_regsel;
    logic [3:0] w_alu_funsel;
    logic [1:0] w_arf_outcsel;
    logic [1:0] w_arf_outdsel;
    logic [1:0] w_arf_funsel;
    logic [2:0] w_arf_regsel;
    logic       w_ir_lh;
    logic       w_ir_enable;
    logic [1:0] w_ir_funsel;
    logic       w_mem_wr;
    logic       w_mem_cs;
    logic [1:0] w_muxasel;
    logic [1:0] w_muxbsel;
    logic       w_muxcsel;
    logic       w_unused_bits;

    assign w_opcode      = IROut[15:12];
    assign w_dst         = IROut[11:10];
    // One-cold register select: DST=0 clears bit 3, DST=3 clears bit 0.
    assign w_dst_sel     = ~(4'b1000 >> w_dst);
    assign w_unused_bits = ^{IROut[5:0], ALUOutFlag[2:0]};

`ifdef FDC_ILLEGAL_TRAP_EN
    assign w_trap = (w_opcode > c_OP_HLT);
`else
    assign w_trap = 1'b0;
`endif

    always_comb begin
        w_rf_outasel  = 2'b00;
        w_rf_outbsel  = 2'b00;
        w_rf_funsel   = 2'b00;
        w_rf_regsel   = 4'b1111;
        w_alu_funsel  = 4'b0000;
        w_arf_outcsel = 2'b00;
        w_arf_outdsel = 2'b00;
        w_arf_funsel  = 2'b00;
        w_arf_regsel  = 3'b111;
        w_ir_lh       = 1'b0;
        w_ir_enable   = 1'b0;
        w_ir_funsel   = 2'b00;
        w_mem_wr      = 1'b0;
        w_mem_cs      = 1'b1;
        w_muxasel     = 2'b00;
        w_muxbsel     = 2'b00;
        w_muxcsel     = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH_L, S_FETCH_H: begin
                    w_mem_cs      = 1'b0;
                    w_arf_outdsel = 2'b11;
                    w_ir_enable   = 1'b1;
                    w_ir_lh       = (r_state == S_FETCH_H);
                    w_ir_funsel   = 2'b10;
                    w_arf_regsel  = 3'b011;
                    w_arf_funsel  = 2'b01;
                end
                S_EXEC: begin
                    if (!w_opcode[3]) begin
                        w_rf_outasel = IROut[9:8];
                        w_rf_outbsel = IROut[7:6];
                        w_alu_funsel = w_opcode;
                        w_muxasel    = 2'b11;
                        w_rf_funsel  = 2'b10;
                        w_rf_regsel  = w_dst_sel;
                    end else if (w_opcode == c_OP_LDI) begin
                        w_muxasel    = 2'b01;
                        w_rf_funsel  = 2'b10;
                        w_rf_regsel  = w_dst_sel;
                    end else if (w_opcode == c_OP_BEQ && ALUOutFlag[3]) begin
                        w_muxbsel    = 2'b01;
                        w_arf_funsel = 2'b10;
                        w_arf_regsel = 3'b011;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH_L: w_next_state = S_FETCH_H;
            S_FETCH_H: w_next_state = S_EXEC;
            S_EXEC:    w_next_state = (w_opcode == c_OP_HLT || w_trap) ? S_HALT : S_FETCH_L;
            default:   w_next_state = S_HALT;
        endcase
    end

    always_comb begin
        w_t_next = 8'h00;
        case (w_next_state)
            S_FETCH_L: w_t_next = 8'b0000_0001;
            S_FETCH_H: w_t_next = 8'b0000_0010;
            S_EXEC:    w_t_next = 8'b0000_0100;
            default:   w_t_next = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FETCH_L;
            r_t     <= 8'b0000_0001;
            r_halt  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_t     <= w_t_next;
            r_halt  <= (w_next_state == S_HALT);
        end
    end

    assign CtrlWord = {w_rf_outasel, w_rf_outbsel, w_rf_funsel, w_rf_regsel,
                       w_alu_funsel, w_arf_outcsel, w_arf_outdsel, w_arf_funsel,
                       w_arf_regsel, w_ir_lh, w_ir_enable, w_ir_funsel,
                       w_mem_wr, w_mem_cs, w_muxasel, w_muxbsel, w_muxcsel};
    assign T        = r_t;
    assign Halt     = r_halt;

endmodule

`default_nettype wire
